// File: rtl/apb4_ram_slave_if.sv
// APB4 completer bus bundle for apb4_ram_slave.
// The master modport drives the request side and the slave modport drives the response side.
interface apb4_ram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_W-1:0]     PSTRB;
    logic [2:0]            PPROT;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_ram_slave.sv
// APB4 completer in front of a word-organised scratch RAM.
// It supports programmable wait states, byte-lane write merging and address-range decode errors.
// Optional PPROT access protection is enabled by defining APB_RAM_PROT_CHECK_EN.
module apb4_ram_slave #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEM_DEPTH    = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           WAIT_STATES  = 0,
    parameter int unsigned           SECURE_WORDS = 256
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb4_ram_slave_if.slave apb
);
    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
    localparam int unsigned OFF_W   = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W   = 4;
    localparam logic [OFF_W-1:0] MEM_BYTES = OFF_W'(MEM_DEPTH * STRB_W);

    // Elaboration-time parameter sanity checks
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
        $error("apb4_ram_slave: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("apb4_ram_slave: MEM_DEPTH must be a power of two >= 2");
    end
    if ((OFF_W'(BASE_ADDR) & (MEM_BYTES - OFF_W'(1))) != '0) begin : g_bad_base
        $error("apb4_ram_slave: BASE_ADDR must be aligned to the RAM size");
    end
    if (WAIT_STATES > 15) begin : g_bad_ws
        $error("apb4_ram_slave: WAIT_STATES must be 0..15");
    end
    if (SECURE_WORDS > MEM_DEPTH) begin : g_bad_secure
        $error("apb4_ram_slave: SECURE_WORDS must not exceed MEM_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [STRB_W-1:0]     strb_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;
    logic                  ready_q;
`ifdef APB_RAM_PROT_CHECK_EN
    localparam int unsigned SECURE_BASE = MEM_DEPTH - SECURE_WORDS;
    logic [1:0]            prot_q;      // {instruction, non-secure}
    logic [1:0]            cur_prot_c;
`endif

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  setup_c;
    logic                  in_idle_c;
    logic [ADDR_WIDTH-1:0] cur_addr_c;
    logic                  cur_write_c;
    logic [STRB_W-1:0]     cur_strb_c;
    logic [OFF_W-1:0]      off_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  dec_err_c;
    logic                  strb_err_c;
    logic                  prot_err_c;
    logic                  err_c;
    logic                  go_access_c;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // Transfer attributes: the live bus in the setup cycle, the captured copy afterwards
    always_comb begin
        setup_c     = apb.PSEL & ~apb.PENABLE;
        in_idle_c   = (state_q == S_IDLE);
        cur_addr_c  = in_idle_c ? apb.PADDR  : addr_q;
        cur_write_c = in_idle_c ? apb.PWRITE : write_q;
        cur_strb_c  = in_idle_c ? apb.PSTRB  : strb_q;
`ifdef APB_RAM_PROT_CHECK_EN
        cur_prot_c  = in_idle_c ? {apb.PPROT[2], apb.PPROT[1]} : prot_q;
`endif
    end

    // Address decode and error classification
    always_comb begin
        off_c      = {1'b0, cur_addr_c} - {1'b0, BASE_ADDR};
        dec_err_c  = (off_c >= MEM_BYTES);
        idx_c      = off_c[IDX_LSB +: IDX_W];
        strb_err_c = ~cur_write_c & (|cur_strb_c);
`ifdef APB_RAM_PROT_CHECK_EN
        prot_err_c = (cur_prot_c[0] & ~dec_err_c & ({1'b0, idx_c} >= (IDX_W + 1)'(SECURE_BASE)))
                   | (cur_write_c & cur_prot_c[1]);
`else
        prot_err_c = 1'b0;
`endif
        err_c      = dec_err_c | strb_err_c | prot_err_c;
        rd_word_c  = mem[idx_c];
    end

    // Flags the clock edge that enters the access phase
    always_comb begin
        go_access_c = 1'b0;
        case (state_q)
            S_IDLE:  go_access_c = setup_c && (WAIT_STATES == 0);
            S_WAIT:  go_access_c = apb.PSEL && (cnt_q == '0);
            default: go_access_c = 1'b0;
        endcase
        mem_we_c = (state_q == S_ACCESS) && write_q && !pslverr_q;
    end

    // Transfer FSM with registered response outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            wdata_q   <= '0;
`ifdef APB_RAM_PROT_CHECK_EN
            prot_q    <= '0;
`endif
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q   <= go_access_c;
            pslverr_q <= go_access_c & err_c;
            if (go_access_c) begin
                if (!cur_write_c) begin
                    prdata_q <= err_c ? '0 : rd_word_c;
                end else if (prot_err_c) begin
                    prdata_q <= '0;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (setup_c) begin
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        strb_q  <= apb.PSTRB;
                        wdata_q <= apb.PWDATA;
`ifdef APB_RAM_PROT_CHECK_EN
                        prot_q  <= {apb.PPROT[2], apb.PPROT[1]};
`endif
                        if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (!apb.PSEL) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_ACCESS: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Byte-lane merged RAM write, committed at the end of the access cycle
    always_ff @(posedge PCLK) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (strb_q[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PREADY  = ready_q & apb.PSEL & apb.PENABLE;

endmodule

// File: tb/tb_apb4_ram_slave.sv
// Self-checking bench for apb4_ram_slave using a byte-addressed reference memory.
// Build with APB_RAM_PROT_CHECK_EN defined to include the protection scenarios.
module tb_apb4_ram_slave;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned WS     = 2;
    localparam int unsigned SW     = 8;
    localparam int unsigned NBYTES = DEPTH * DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    apb4_ram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_ram_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_DEPTH   (DEPTH),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (WS),
        .SECURE_WORDS(SW)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .apb    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] ref_prdata = '0;

    // Reference: byte-addressed memory plus the held read-data register
    task automatic ref_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, output logic exp_slv);
        logic        in_rng;
        logic        perr;
        int unsigned base;
        in_rng = (addr < NBYTES);
        perr   = 1'b0;
`ifdef APB_RAM_PROT_CHECK_EN
        perr = (prot[1] && in_rng && (addr / 4 >= DEPTH - SW)) || (wr && prot[2]);
`endif
        exp_slv = !in_rng || (!wr && strb != 4'h0) || perr;
        base    = (addr / 4) * 4;
        if (wr) begin
            if (!exp_slv) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) ref_mem[base + i] = wdata[8*i +: 8];
                end
            end
            if (perr) ref_prdata = '0;
        end else begin
            ref_prdata = exp_slv ? 32'h0 :
                {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
        end
    endtask

    // One APB transfer starting at the next falling edge; cyc counts PCLK cycles incl. setup
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rd, output logic slv, output int cyc);
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
        bus.PWDATA = wdata; bus.PSTRB = strb; bus.PPROT = prot;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        cyc = 2;
        rd  = 'x;
        slv = 1'bx;
        for (int k = 0; k < 32; k++) begin
            #1;
            if (bus.PREADY === 1'b1) begin
                rd  = bus.PRDATA;
                slv = bus.PSLVERR;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic xfer_ref(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rd, output logic slv, output logic exp_slv,
                            output int cyc);
        apb_xfer(wr, addr, wdata, strb, prot, rd, slv, cyc);
        ref_xfer(wr, addr, wdata, strb, prot, exp_slv);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0;
        bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.PREADY !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b expected 0", bus.PREADY); end
        n_checks++; if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b expected 0", bus.PSLVERR); end
        n_checks++; if (bus.PRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", bus.PRDATA); end
        rst_n = 1'b1;
        ref_prdata = '0;
    endtask

    task automatic test_fill();
        logic [31:0] rd; logic slv, es; int cyc;
        for (int w = 0; w < int'(DEPTH); w++) begin
            xfer_ref(1'b1, 32'(w * 4), $urandom, 4'hF, 3'b000, rd, slv, es, cyc);
            n_checks++; if (slv !== es) begin n_fail++; $display("FAIL fill_err w%0d: got %b expected %b", w, slv, es); end
        end
        bus_idle();
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; logic slv, es; int cyc;
        xfer_ref(1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b0) begin n_fail++; $display("FAIL merge_w1_err: got %b expected 0", slv); end
        xfer_ref(1'b1, 32'h10, 32'h11223344, 4'b0101, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b0) begin n_fail++; $display("FAIL merge_w2_err: got %b expected 0", slv); end
        xfer_ref(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'hAA22CC44) begin n_fail++; $display("FAIL merge_read: got %h expected aa22cc44", rd); end
        n_checks++; if (slv !== 1'b0) begin n_fail++; $display("FAIL merge_read_err: got %b expected 0", slv); end
        xfer_ref(1'b0, 32'h13, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'hAA22CC44) begin n_fail++; $display("FAIL unaligned_read: got %h expected aa22cc44", rd); end
        xfer_ref(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b0) begin n_fail++; $display("FAIL zero_strb_err: got %b expected 0", slv); end
        xfer_ref(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'hAA22CC44) begin n_fail++; $display("FAIL zero_strb_read: got %h expected aa22cc44", rd); end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic slv, es; int cyc;
        xfer_ref(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (cyc != int'(WS + 2)) begin n_fail++; $display("FAIL wait_latency: got %0d expected %0d", cyc, WS + 2); end
        n_checks++; if (rd !== ref_prdata) begin n_fail++; $display("FAIL b2b_read0: got %h expected %h", rd, ref_prdata); end
        xfer_ref(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (cyc != int'(WS + 2)) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, WS + 2); end
        n_checks++; if (rd !== ref_prdata) begin n_fail++; $display("FAIL b2b_read4: got %h expected %h", rd, ref_prdata); end
        bus_idle();
    endtask

    task automatic test_decode();
        logic [31:0] rd; logic slv, es; int cyc;
        xfer_ref(1'b1, 32'h0, 32'h12345678, 4'hF, 3'b000, rd, slv, es, cyc);
        xfer_ref(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL decode_pre: got %h expected 12345678", rd); end
        xfer_ref(1'b0, NBYTES, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b1) begin n_fail++; $display("FAIL decode_oor_err: got %b expected 1", slv); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL decode_oor_data: got %h expected 0", rd); end
        xfer_ref(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        xfer_ref(1'b0, 32'h0, 32'h0, 4'h1, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b1) begin n_fail++; $display("FAIL rd_strb_err: got %b expected 1", slv); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd_strb_data: got %h expected 0", rd); end
        xfer_ref(1'b1, NBYTES, 32'hFFFFFFFF, 4'hF, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b1) begin n_fail++; $display("FAIL wr_oor_err: got %b expected 1", slv); end
        xfer_ref(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b1) begin n_fail++; $display("FAIL rd_top_err: got %b expected 1", slv); end
        bus_idle();
        #1;
        n_checks++; if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL pslverr_idle: got %b expected 0", bus.PSLVERR); end
        xfer_ref(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wr_oor_alias: got %h expected 12345678", rd); end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic slv, es; int cyc;
        xfer_ref(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 3'b000, rd, slv, es, cyc);
        bus_idle();
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h20;
        bus.PWDATA = 32'hDEADBEEF; bus.PSTRB = 4'hF; bus.PPROT = 3'b000;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.PREADY !== 1'b0) begin n_fail++; $display("FAIL abort_pready c%0d: got %b expected 0", k, bus.PREADY); end
        end
        xfer_ref(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL abort_read: got %h expected 0badf00d", rd); end
        bus_idle();
    endtask

`ifdef APB_RAM_PROT_CHECK_EN
    task automatic test_prot();
        logic [31:0] rd; logic slv, es; logic [31:0] top; int cyc;
        top = 32'((DEPTH - 1) * 4);
        xfer_ref(1'b1, top, 32'hCAFE0001, 4'hF, 3'b000, rd, slv, es, cyc);
        xfer_ref(1'b1, top, 32'h5555AAAA, 4'hF, 3'b010, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b1) begin n_fail++; $display("FAIL prot_ns_err: got %b expected 1", slv); end
        xfer_ref(1'b0, top, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL prot_ns_kept: got %h expected cafe0001", rd); end
        xfer_ref(1'b1, top, 32'h5555AAAA, 4'hF, 3'b000, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b0) begin n_fail++; $display("FAIL prot_s_err: got %b expected 0", slv); end
        xfer_ref(1'b0, top, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (rd !== 32'h5555AAAA) begin n_fail++; $display("FAIL prot_s_read: got %h expected 5555aaaa", rd); end
        xfer_ref(1'b1, 32'h0, 32'h77777777, 4'hF, 3'b100, rd, slv, es, cyc);
        n_checks++; if (slv !== 1'b1) begin n_fail++; $display("FAIL prot_instr_err: got %b expected 1", slv); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL prot_instr_data: got %h expected 0", rd); end
        bus_idle();
    endtask
`endif

    task automatic test_random();
        logic wr; logic [31:0] addr, wdata, rd; logic [3:0] strb; logic [2:0] prot;
        logic slv, es; int cyc;
        for (int n = 0; n < 200; n++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, NBYTES + 63));
            wdata = $urandom;
            if (wr) strb = 4'($urandom_range(0, 15));
            else    strb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            prot  = 3'($urandom_range(0, 7));
            xfer_ref(wr, addr, wdata, strb, prot, rd, slv, es, cyc);
            n_checks++; if (slv !== es) begin n_fail++; $display("FAIL rand_err #%0d wr=%b a=%h: got %b expected %b", n, wr, addr, slv, es); end
            n_checks++; if (rd !== ref_prdata) begin n_fail++; $display("FAIL rand_data #%0d wr=%b a=%h: got %h expected %h", n, wr, addr, rd, ref_prdata); end
        end
        bus_idle();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic slv, es; int cyc;
        xfer_ref(1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, 3'b000, rd, slv, es, cyc);
        xfer_ref(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        bus_idle();
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h8;
        bus.PSTRB = 4'h0; bus.PPROT = 3'b000;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.PREADY !== 1'b0) begin n_fail++; $display("FAIL rst_wait_pready: got %b expected 0", bus.PREADY); end
        n_checks++; if (bus.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL rst_wait_pslverr: got %b expected 0", bus.PSLVERR); end
        n_checks++; if (bus.PRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_wait_prdata: got %h expected 0", bus.PRDATA); end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        ref_prdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer_ref(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, slv, es, cyc);
        n_checks++; if (cyc != int'(WS + 2)) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected %0d", cyc, WS + 2); end
        n_checks++; if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL rst_next_data: got %h expected 5a5a5a5a", rd); end
        n_checks++; if (slv !== 1'b0) begin n_fail++; $display("FAIL rst_next_err: got %b expected 0", slv); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_byte_merge();
        test_wait_states();
        test_decode();
        test_abort();
`ifdef APB_RAM_PROT_CHECK_EN
        test_prot();
`endif
        test_random();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
